// File: rtl/dbus_sram_responder.sv
// Data-bus responder: answers dbus requests from a local 64-bit-word SRAM after a
// fixed programmable latency, with byte-strobe writes committed at the end of the response.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       oor,
    output logic [1:0] dbg_state
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    // Handshake: the initiator holds valid until addr_ok/data_ok (always together,
    // one cycle); dropping valid while waiting flushes the request uncommitted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [63:0]  addr_q, data_q;
    logic [7:0]   strobe_q;
    logic         capture;
    logic [63:0]  mem [DEPTH];

    logic [63:0]  sel_addr, sel_off, cap_off;
    logic         sel_in_range, cap_in_range;
    logic [AW-1:0] sel_idx, cap_idx;
    logic         unused_size;

    // With LATENCY=1 the response is produced straight from IDLE, so the read
    // address comes from the live request rather than the capture register.
    assign sel_addr     = (state_q == IDLE) ? dreq.addr : addr_q;
    assign sel_off      = sel_addr - BASE;
    assign sel_in_range = (sel_addr >= BASE) && (sel_off < SPAN);
    assign sel_idx      = sel_off[AW+2:3];

    assign cap_off      = addr_q - BASE;
    assign cap_in_range = (addr_q >= BASE) && (cap_off < SPAN);
    assign cap_idx      = cap_off[AW+2:3];

    assign unused_size  = ^dreq.size;
    assign dbg_state    = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    capture = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!dreq.valid) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 64'd0;
            data_q   <= 64'd0;
            strobe_q <= 8'd0;
            dresp    <= '0;
            oor      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q   <= dreq.addr;
                data_q   <= dreq.data;
                strobe_q <= dreq.strobe;
            end
            // Response is registered on entry to RESP; the read sees the pre-write word.
            if (state_d == RESP) begin
                dresp.addr_ok <= 1'b1;
                dresp.data_ok <= 1'b1;
                dresp.data    <= sel_in_range ? mem[sel_idx] : 64'd0;
                oor           <= !sel_in_range;
            end else begin
                dresp <= '0;
                oor   <= 1'b0;
            end
        end
    end

    // Commit on the edge ending RESP; reset forces IDLE so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (state_q == RESP && strobe_q != 8'd0 && cap_in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) mem[cap_idx][8*i +: 8] <= data_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: three instances (LATENCY 2, 1, 3) driven
// in sequence, responses checked against a queue of expected results.
module tb_dbus_sram_responder;
    import dbus_pkg::*;

    localparam logic [63:0] BASE    = 64'h8000_0000;
    localparam logic [63:0] SPAN    = 64'd8192;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_WAIT = 2'd1;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  req  [3];
    dbus_resp_t resp [3];
    logic       oor  [3];
    logic [1:0] st   [3];

    logic [65:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dbus_sram_responder #(.LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .dreq(req[0]), .dresp(resp[0]), .oor(oor[0]), .dbg_state(st[0])
    );
    dbus_sram_responder #(.LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .dreq(req[1]), .dresp(resp[1]), .oor(oor[1]), .dbg_state(st[1])
    );
    dbus_sram_responder #(.LATENCY(3)) u_lat3 (
        .clk(clk), .reset(reset), .dreq(req[2]), .dresp(resp[2]), .oor(oor[2]), .dbg_state(st[2])
    );

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0 of the request.
    task automatic run_req(input int d, input logic [63:0] addr, input logic [7:0] strb,
                           input logic [63:0] wdata, input logic chk, input logic exp_oor,
                           input logic [63:0] exp_data);
        int lat;
        logic [65:0] e;
        bit got;
        lat = (d == 0) ? 2 : (d == 1) ? 1 : 3;
        exp_q.push_back({chk, exp_oor, exp_data});
        req[d].valid  = 1'b1;
        req[d].addr   = addr;
        req[d].size   = 3'd3;
        req[d].strobe = strb;
        req[d].data   = wdata;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            check1("ack_pair", resp[d].addr_ok, resp[d].data_ok);
            if (resp[d].data_ok) begin
                got = 1'b1;
                req[d].valid  = 1'b0;
                req[d].strobe = 8'd0;
                check32("resp_cycle", k, lat);
                e = exp_q.pop_front();
                check1("resp_oor", oor[d], e[64]);
                if (e[65]) check64("resp_data", resp[d].data, e[63:0]);
            end else begin
                check1("early_oor", oor[d], 1'b0);
                check64("early_data", resp[d].data, 64'd0);
            end
        end
        check1("response_seen", got, 1'b1);
        if (!got) begin
            req[d].valid = 1'b0;
            e = exp_q.pop_front();
        end else begin
            @(negedge clk);
            check32("post_state", st[d], ST_IDLE);
            check1("post_data_ok", resp[d].data_ok, 1'b0);
            check1("post_oor", oor[d], 1'b0);
            check64("post_data", resp[d].data, 64'd0);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) req[d] = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check32("rst_state", st[d], ST_IDLE);
            check1("rst_addr_ok", resp[d].addr_ok, 1'b0);
            check1("rst_data_ok", resp[d].data_ok, 1'b0);
            check64("rst_data", resp[d].data, 64'd0);
            check1("rst_oor", oor[d], 1'b0);
        end
        reset = 1'b1;

        // LATENCY=2: preload, aligned read via unaligned address, byte-strobe write
        run_req(0, BASE, 8'hff, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 64'd0);
        run_req(0, BASE + 64'd4, 8'h00, 64'd0, 1'b1, 1'b0, 64'h1122_3344_5566_7788);
        run_req(0, BASE + 64'd8, 8'hff, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b0, 64'd0);
        run_req(0, BASE + 64'd8, 8'h0c, 64'h0000_0000_abcd_0000, 1'b1, 1'b0, 64'hffff_ffff_ffff_ffff);
        run_req(0, BASE + 64'd8, 8'h00, 64'd0, 1'b1, 1'b0, 64'hffff_ffff_abcd_ffff);

        // Range boundaries: last word in range, one past the end, one before base
        run_req(0, BASE + SPAN - 64'd8, 8'hff, 64'ha5a5_5a5a_a5a5_5a5a, 1'b0, 1'b0, 64'd0);
        run_req(0, BASE + SPAN, 8'h00, 64'd0, 1'b1, 1'b1, 64'd0);
        run_req(0, BASE - 64'd8, 8'hff, 64'hdead_beef_dead_beef, 1'b1, 1'b1, 64'd0);
        run_req(0, BASE + SPAN - 64'd8, 8'h00, 64'd0, 1'b1, 1'b0, 64'ha5a5_5a5a_a5a5_5a5a);
        run_req(0, BASE, 8'h00, 64'd0, 1'b1, 1'b0, 64'h1122_3344_5566_7788);

        // Async reset in WAIT aborts the pending write
        run_req(0, BASE + 64'd16, 8'hff, 64'h0123_4567_89ab_cdef, 1'b0, 1'b0, 64'd0);
        req[0].valid  = 1'b1;
        req[0].addr   = BASE + 64'd16;
        req[0].strobe = 8'hff;
        req[0].data   = 64'hffff_0000_ffff_0000;
        @(negedge clk);
        check32("wait_state", st[0], ST_WAIT);
        #1 reset = 1'b0;
        #1;
        check32("arst_wait_state", st[0], ST_IDLE);
        check1("arst_wait_data_ok", resp[0].data_ok, 1'b0);
        check64("arst_wait_data", resp[0].data, 64'd0);
        req[0].valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Async reset in RESP clears the response at once and drops the write
        req[0].valid  = 1'b1;
        req[0].data   = 64'h5555_aaaa_5555_aaaa;
        repeat (2) @(negedge clk);
        check1("pre_arst_data_ok", resp[0].data_ok, 1'b1);
        check64("pre_arst_data", resp[0].data, 64'h0123_4567_89ab_cdef);
        #1 reset = 1'b0;
        #1;
        check1("arst_resp_addr_ok", resp[0].addr_ok, 1'b0);
        check1("arst_resp_data_ok", resp[0].data_ok, 1'b0);
        check64("arst_resp_data", resp[0].data, 64'd0);
        check1("arst_resp_oor", oor[0], 1'b0);
        req[0].valid  = 1'b0;
        req[0].strobe = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        run_req(0, BASE + 64'd16, 8'h00, 64'd0, 1'b1, 1'b0, 64'h0123_4567_89ab_cdef);

        // LATENCY=1 back-to-back reads: responses in cycles 1 and 3
        run_req(1, BASE, 8'hff, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'd0);
        run_req(1, BASE + 64'd8, 8'hff, 64'h0000_0000_0000_0002, 1'b0, 1'b0, 64'd0);
        run_req(1, BASE, 8'h00, 64'd0, 1'b1, 1'b0, 64'h0000_0000_0000_0001);
        run_req(1, BASE + 64'd8, 8'h00, 64'd0, 1'b1, 1'b0, 64'h0000_0000_0000_0002);

        // LATENCY=3 flush: valid dropped in cycle 1, nothing committed
        run_req(2, BASE + 64'd16, 8'hff, 64'h3333_3333_3333_3333, 1'b0, 1'b0, 64'd0);
        req[2].valid  = 1'b1;
        req[2].addr   = BASE + 64'd16;
        req[2].strobe = 8'hff;
        req[2].data   = 64'hdead_beef_dead_beef;
        @(negedge clk);
        check32("flush_wait_state", st[2], ST_WAIT);
        req[2].valid  = 1'b0;
        req[2].strobe = 8'd0;
        @(negedge clk);
        check32("flush_idle_state", st[2], ST_IDLE);
        repeat (4) begin
            @(negedge clk);
            check1("flush_no_resp", resp[2].data_ok, 1'b0);
        end
        run_req(2, BASE + 64'd16, 8'h00, 64'd0, 1'b1, 1'b0, 64'h3333_3333_3333_3333);

        check32("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
